mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (I) and the load/store port (D) of the RISC-V core.
- Lets the core move from split inst/data memories to one memory.
- Serialises accesses with one transaction outstanding, fixed D-over-I priority and a starvation guard for fetch.
- Signals completion with one-cycle done pulses that the core uses as stall release.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; must be a multiple of 8
STARVE_LIMIT, 4, consecutive D grants issued while I is waiting, after which I wins the next arbitration (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_req  input  1  fetch request; held with i_addr stable until i_done
i_addr  input  ADDR_W  fetch address
i_done  output  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  output  DATA_W  fetch data; holds until next i_done
d_req  input  1  load/store request; fields held stable until d_done
d_we  input  1  1=store, 0=load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_be  input  DATA_W/8  store byte enables
d_done  output  1  one-cycle pulse: load/store complete
d_rdata  output  DATA_W  load data; holds until next d_done
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  write enable to memory
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_ack  input  1  memory accepted/completed the request this cycle; mem_rdata valid for reads
mem_rdata  input  DATA_W  memory read data
spurious_ack  output  1  sticky: mem_ack seen while mem_req=0

Behaviour:
- Reset values: state IDLE, starvation counter 0, spurious_ack 0.
- All outputs are registered and reset to 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, i_done, d_done, i_rdata, d_rdata.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - d_req only -> D. i_req only -> I.
  - Both requesting: I if starve_cnt == STARVE_LIMIT, else D.
  - Neither requesting: stay in IDLE.
- Granting D: the next edge loads mem_addr/we/wdata/be from d_* and sets mem_req=1 -> BUSY_D.
- Granting I: mem_we=0, mem_be all-ones, mem_wdata=0, mem_req=1 -> BUSY_I.
- BUSY_x:
  - mem_req and mem_* fields stay constant while mem_ack=0; there is no timeout.
  - Edge with mem_ack=1: mem_req<=0 and x_done<=1 for exactly one cycle.
  - For BUSY_I, and for BUSY_D with mem_we=0, x_rdata<=mem_rdata. Store completion leaves d_rdata unchanged.
  - Then -> IDLE.
- mem_ack is allowed in the first cycle mem_req is high (zero wait states).
- Latency: request sampled in IDLE at cycle N -> mem_req high at N+1 -> done pulse at N+2+W, where W = wait cycles before mem_ack.
- Back-to-back: the IDLE cycle carrying x_done is a normal arbitration cycle. A requester holding req high there presents a new transaction. Peak throughput is one access per 2 cycles.
- Requests arriving in BUSY states are not sampled until IDLE. A requester must not drop req before its done.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - +1 on each D grant made while i_req=1, saturating at STARVE_LIMIT.
  - Cleared on an I grant, or in IDLE when i_req=0.
- mem_ack while in IDLE: ignored for data and state; sets spurious_ack, which stays set until rst.
- Reset mid-transaction: next edge forces IDLE and clears mem_req and dones. The in-flight access is abandoned, and no done pulse is produced for it. The memory is reset by the same rst.
- Done pulses never overlap; at most one of i_done/d_done is high in any cycle.

Test Plan:
- Single fetch: i_req=1, i_addr=0x10, mem_ack the cycle after mem_req with mem_rdata=0x00208033 -> mem_req high exactly 1 cycle, mem_we=0, mem_be=4'hF; i_done pulses 2 cycles after request; i_rdata=0x00208033.
- Store with wait states: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011, mem_ack after 3 wait cycles -> mem_* stable for 4 cycles; d_done on the following cycle; d_rdata unchanged.
- Contention and starvation (STARVE_LIMIT=4): i_req and d_req held continuously with back-to-back loads -> grant order D,D,D,D,I,D,D,D,D,I; no done pulse for the 2nd D while the 1st is in flight.
- Simultaneous request after done: fetch completes while d_req rises in the done cycle -> D granted next, mem_req high the cycle after d_done/i_done.
- Reset mid-op: rst for 1 cycle during BUSY_D with mem_ack never asserted -> mem_req=0, no d_done, state IDLE; a subsequent fetch completes normally.
- Spurious ack: mem_ack=1 while idle -> spurious_ack=1 and held; i_done/d_done stay 0; cleared only by rst.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// One access in flight, D wins ties unless fetch has been passed over STARVE_LIMIT times.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_done,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_done,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                spurious_ack
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] { IDLE, BUSY_I, BUSY_D } state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic             grant_i;
   logic             grant_d;

   // Only meaningful in IDLE; a starved fetch overrides the D priority.
   always_comb begin
      grant_d = d_req && !(i_req && (starve_cnt == LIMIT));
      grant_i = i_req && !grant_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         starve_cnt   <= '0;
         spurious_ack <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_be       <= '0;
         i_done       <= 1'b0;
         d_done       <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         if (mem_ack && !mem_req)
            spurious_ack <= 1'b1;

         case (state)
            IDLE: begin
               if (grant_d) begin
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_be    <= d_be;
                  state     <= BUSY_D;
               end else if (grant_i) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= i_addr;
                  mem_wdata <= '0;
                  mem_be    <= '1;
                  state     <= BUSY_I;
               end

               if (grant_i || !i_req)
                  starve_cnt <= '0;
               else if (grant_d && (starve_cnt != LIMIT))
                  starve_cnt <= starve_cnt + 1'b1;
            end

            BUSY_I: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  i_done  <= 1'b1;
                  i_rdata <= mem_rdata;
                  state   <= IDLE;
               end
            end

            BUSY_D: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  d_done  <= 1'b1;
                  // Store completion must not disturb the last load result.
                  if (!mem_we)
                     d_rdata <= mem_rdata;
                  state   <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model with a byte-addressed memory image.
module tb_mem_port_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_done;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [3:0]    d_be;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          spurious_ack;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .spurious_ack(spurious_ack)
   );

   int total  = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Memory image: unwritten words read back as a pattern derived from the address.
   logic [31:0] mem_arr [logic [31:0]];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : {a[15:0], 16'h5A5A};
   endfunction

   task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = mem_read(a);
      for (int b = 0; b < 4; b++)
         if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      mem_arr[a] = w;
   endtask

   // Reference model: the transaction in flight, fetch wait count, expected outputs.
   bit          m_busy = 1'b0;
   bit          m_port_d = 1'b0;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   int          m_wait = 0;
   int          starve = 0;
   logic [31:0] e_irdata;
   logic [31:0] e_drdata;
   bit          e_idone, e_ddone, e_spur;

   int  fixed_wait = 0;
   int  wait_max   = 0;
   bit  auto_req   = 1'b0;
   bit  auto_new   = 1'b0;
   bit  spur_now   = 1'b0;
   bit  prev_req   = 1'b0;
   byte glog[$];

   // One clock: respond as the memory, advance the model, clock, compare, update requesters.
   task automatic step();
      logic ack, gd, gi;
      ack = 1'b0;
      if (m_busy) begin
         if (m_wait == 0) ack = 1'b1;
         else m_wait--;
      end
      if (spur_now) ack = 1'b1;
      mem_ack   = ack;
      mem_rdata = (m_busy && !m_we) ? mem_read(m_addr) : $urandom();

      e_idone = 1'b0;
      e_ddone = 1'b0;
      if (rst) begin
         m_busy = 1'b0; starve = 0; e_spur = 1'b0; e_irdata = '0; e_drdata = '0;
      end else if (m_busy) begin
         if (ack) begin
            m_busy = 1'b0;
            if (m_port_d) begin
               e_ddone = 1'b1;
               if (m_we) mem_write(m_addr, m_wdata, m_be);
               else e_drdata = mem_rdata;
            end else begin
               e_idone  = 1'b1;
               e_irdata = mem_rdata;
            end
         end
      end else begin
         if (ack) e_spur = 1'b1;
         gd = d_req && !(i_req && starve >= LIMIT);
         gi = i_req && !gd;
         if (gd) begin
            m_busy = 1'b1; m_port_d = 1'b1; m_we = d_we; m_addr = d_addr;
            m_wdata = d_wdata; m_be = d_be;
         end else if (gi) begin
            m_busy = 1'b1; m_port_d = 1'b0; m_we = 1'b0; m_addr = i_addr;
            m_wdata = '0; m_be = 4'hF;
         end
         if (gi || !i_req) starve = 0;
         else if (gd) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         if (gd || gi) m_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
      end

      @(posedge clk);
      #1;
      chk("i_done", i_done, e_idone);
      chk("d_done", d_done, e_ddone);
      chk("done_overlap", i_done & d_done, 1'b0);
      chk("mem_req", mem_req, m_busy);
      if (m_busy) begin
         chk("mem_we", mem_we, m_we);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
         chk("mem_be", mem_be, m_be);
      end
      chk("i_rdata", i_rdata, e_irdata);
      chk("d_rdata", d_rdata, e_drdata);
      chk("spurious_ack", spurious_ack, e_spur);
      if (mem_req && !prev_req) glog.push_back((mem_addr == 32'h1000) ? 8'h49 : 8'h44);
      prev_req = mem_req;
      mem_ack  = 1'b0;
      spur_now = 1'b0;

      if (auto_req) begin
         if (e_idone) i_req = 1'b0;
         if (e_ddone) d_req = 1'b0;
         if (auto_new && !i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = 32'($urandom_range(0, 15)) << 2;
         end
         if (auto_new && !d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom_range(0, 15)) << 2;
            d_wdata = $urandom();
            d_be    = 4'($urandom_range(0, 15));
         end
      end
   endtask

   initial begin
      int    n;
      bit    seen;
      string exp_order;
      exp_order = "DDDDIDDDDI";

      rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
      d_wdata = '0; d_be = '0; mem_ack = 1'b0; mem_rdata = '0;
      mem_arr[32'h10] = 32'h00208033;
      mem_arr[32'h40] = 32'hCAFEF00D;
      fixed_wait = 0;

      // Reset state
      step(); step();
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_be", mem_be, 4'h0);
      rst = 1'b0;

      // Single zero-wait fetch
      i_req = 1'b1; i_addr = 32'h10;
      step();
      chk("fetch_mem_req", mem_req, 1'b1);
      chk("fetch_mem_we", mem_we, 1'b0);
      chk("fetch_mem_be", mem_be, 4'hF);
      step();
      chk("fetch_done", i_done, 1'b1);
      chk("fetch_rdata", i_rdata, 32'h00208033);
      chk("fetch_req_low", mem_req, 1'b0);
      i_req = 1'b0;
      step();
      chk("fetch_done_pulse", i_done, 1'b0);

      // Load, then a store with 3 wait states that must leave d_rdata alone
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      step(); step();
      chk("load_rdata", d_rdata, 32'hCAFEF00D);
      d_req = 1'b0;
      step();
      fixed_wait = 3;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
      n = 0;
      for (int k = 0; k < 10 && !d_done; k++) begin
         step();
         if (mem_req) n++;
      end
      chk("store_req_cycles", n, 4);
      chk("store_done", d_done, 1'b1);
      chk("store_keeps_rdata", d_rdata, 32'hCAFEF00D);
      d_req = 1'b0; d_we = 1'b0;
      step();

      // Contention with both requesters held: starvation guard lets fetch through
      fixed_wait = 0;
      glog.delete();
      i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 80 && glog.size() < 10; k++) step();
      chk("grant_count", glog.size(), 10);
      for (int k = 0; k < glog.size() && k < 10; k++)
         chk($sformatf("grant_%0d", k), glog[k], exp_order[k]);
      d_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         seen = i_done;
      end
      chk("contention_last_fetch", seen, 1'b1);
      i_req = 1'b0;
      step();

      // D request raised in the fetch done cycle is granted on the next edge
      i_req = 1'b1; i_addr = 32'h10;
      step(); step();
      chk("handoff_i_done", i_done, 1'b1);
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      step();
      chk("handoff_d_grant", mem_req, 1'b1);
      chk("handoff_d_addr", mem_addr, 32'h40);
      step();
      chk("handoff_d_done", d_done, 1'b1);
      d_req = 1'b0;
      step();

      // Reset in the middle of a never-acknowledged load
      fixed_wait = 1000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
      step(); step(); step();
      chk("midrst_busy", mem_req, 1'b1);
      rst = 1'b1; d_req = 1'b0;
      step();
      chk("midrst_req_low", mem_req, 1'b0);
      rst = 1'b0;
      step(); step();
      chk("midrst_no_done", d_done, 1'b0);
      fixed_wait = 1;
      i_req = 1'b1; i_addr = 32'h10;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         seen = i_done;
      end
      chk("midrst_fetch_done", seen, 1'b1);
      chk("midrst_fetch_rdata", i_rdata, 32'h00208033);
      i_req = 1'b0;
      step();

      // Random traffic with random wait states
      fixed_wait = -1; wait_max = 3; auto_req = 1'b1; auto_new = 1'b1;
      repeat (400) step();
      auto_new = 1'b0;
      for (int k = 0; k < 100 && (i_req || d_req || m_busy); k++) step();
      chk("drain", {i_req, d_req, m_busy}, 3'b000);
      auto_req = 1'b0;

      // Spurious ack while idle is sticky until reset
      spur_now = 1'b1;
      step();
      chk("spur_set", spurious_ack, 1'b1);
      chk("spur_no_idone", i_done, 1'b0);
      chk("spur_no_ddone", d_done, 1'b0);
      step(); step();
      chk("spur_held", spurious_ack, 1'b1);
      rst = 1'b1;
      step();
      chk("spur_cleared", spurious_ack, 1'b0);
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
